instr_encoder: RTL
==================

# instr_encoder

Instruction-word encoder and instruction-memory loader for the MIPS core: the inverse of the control decoder. It accepts instruction requests (kind plus register, immediate and target fields) over a valid/ready handshake and encodes each into its 32-bit MIPS word. Encoded words are buffered in a small FIFO and written sequentially into the instruction memory's load port, at auto-incrementing byte addresses starting at the reset PC. Benches and the boot loader use it to build programs without hand-assembling hex.

## Interface
- PC_BASE, 32'h0000_3000: byte address of the first word written after reset or flush.
- ADDR_W, 10: width of the word-offset counter; addresses wrap modulo 2^ADDR_W words.
- FIFO_DEPTH, 4: number of encoded-word entries; a power of two, at least 2.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state.
- flush  in  1  synchronous; empties the FIFO and restarts addressing at PC_BASE.
- in_valid  in  1  request present.
- in_ready  out  1  request can be accepted: !full && !flush.
- in_kind  in  4  0 addu, 1 subu, 2 ori, 3 lw, 4 sw, 5 beq, 6 lui, 7 jal, 8 jr, 9 j; 10–15 illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  16  immediate or offset field.
- in_target  in  26  jump target field.
- im_we  out  1  write request to instruction memory: !empty.
- im_ready  in  1  memory accepts the write this cycle.
- im_addr  out  32  byte address: PC_BASE + 4*offset.
- im_wdata  out  32  FIFO head word.
- err_illegal  out  1  one-cycle pulse after an illegal kind is accepted.
- words_written  out  ADDR_W+1  count of completed writes since reset or flush; saturates at all-ones.

## Operation
- Accept: a request is accepted when in_valid && in_ready. Legal kinds push the encoded word; illegal kinds push nothing and set err_illegal for the next cycle.
- Encodings:
  - addu: {6'h00, rs, rt, rd, 5'h00, 6'h21}
  - subu: same as addu with funct 6'h23
  - ori: {6'h0d, rs, rt, imm}
  - lw: {6'h23, rs, rt, imm}
  - sw: {6'h2b, rs, rt, imm}
  - beq: {6'h04, rs, rt, imm}
  - lui: {6'h0f, 5'h00, rt, imm}
  - jal: {6'h03, target}
  - jr: {6'h00, rs, 15'h0000, 6'h08}
  - j: {6'h02, target}
- Unused input fields are ignored.
- Write: a write completes when im_we && im_ready. On completion:
  - the head entry is popped;
  - offset increments modulo 2^ADDR_W;
  - words_written increments, saturating at all-ones.
- im_addr and im_wdata must stay stable while im_we is high and im_ready is low.
- FIFO occupancy:
  - push and pop in the same cycle leave occupancy unchanged;
  - no push when full, because in_ready is low; there is no bypass path;
  - pop when empty cannot occur, because im_we is low.
- Wrap-around: when offset reaches 2^ADDR_W−1 and a write completes, offset returns to 0 and im_addr returns to PC_BASE. words_written still counts (saturating).
- Flush:
  - during the flush cycle, in_ready is low and any in_valid is dropped with no err_illegal;
  - at the edge, FIFO is cleared, offset = 0, words_written = 0, err_illegal = 0;
  - a write completing in the flush cycle is still presented to memory but is not counted.
- Reset: same effect as flush, and additionally clears FIFO storage to zero.

## Timing
- Reset values: im_we 0, im_addr PC_BASE, im_wdata 0, err_illegal 0, words_written 0, in_ready 1 from the first cycle after reset (when flush is low).
- Latency: a request accepted at edge N drives im_we = 1 with its word from edge N+1 when the FIFO was empty.
- Throughput: one word per cycle when im_ready is held high.
- err_illegal is registered: high for exactly the one cycle after acceptance.
- in_ready is combinational from FIFO state and flush, with no dependence on in_valid. im_we depends only on FIFO state.
- Simultaneous events:
  - reset dominates flush; flush dominates push and pop bookkeeping;
  - a full FIFO with a pop in the same cycle still shows in_ready = 0 that cycle (no same-cycle refill).

## Test plan
- Reset, im_ready = 1; push ori rs=0 rt=1 imm=16'h1234 → next cycle im_we=1, im_addr=32'h0000_3000, im_wdata=32'h3401_1234; then words_written=1 and im_we=0.
- Push all ten kinds back-to-back with rs=1 rt=2 rd=3 imm=16'hfffc target=26'h0000c00 → ten consecutive writes at 3000…3024 with the exact encodings, e.g. addu 32'h0022_1821, jr 32'h0020_0008, j 32'h0800_0c00.
- Hold im_ready = 0 and push 5 requests → in_ready falls after 4 accepts and im_wdata stays stable; release im_ready → 4 words drain in order, and in_ready returns the cycle after the first pop.
- Push in_kind = 12 between two legal requests → err_illegal high for exactly one cycle; only 2 writes occur, at consecutive addresses.
- ADDR_W = 2: write 5 words → im_addr sequence 3000, 3004, 3008, 300c, 3000; words_written = 5.
- Assert flush with 3 words queued and in_valid high → the in_valid request is dropped; next cycle im_we=0, words_written=0; the next push is written at 32'h0000_3000.

Source files
------------

// File: rtl/instr_encoder.sv
// MIPS instruction-word encoder feeding a small FIFO that streams encoded words
// into the instruction memory load port at auto-incrementing byte addresses.
module instr_encoder #(
  parameter logic [31:0] PC_BASE    = 32'h0000_3000,
  parameter int          ADDR_W     = 10,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              im_we,
  input  logic              im_ready,
  output logic [31:0]       im_addr,
  output logic [31:0]       im_wdata,
  output logic              err_illegal,
  output logic [ADDR_W:0]   words_written
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [31:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W:0]    count;
  logic [ADDR_W-1:0] offset;
  logic [31:0]       encWord;
  logic              legal;
  logic              full;
  logic              accept;
  logic              push;
  logic              pop;

  // NOTE: every output of a combinational block gets a default first so that
  // an unlisted case can never infer a latch.
  always_comb begin
    encWord = '0;
    legal   = 1'b1;
    case (in_kind)
      4'd0:    encWord = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h21};
      4'd1:    encWord = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h23};
      4'd2:    encWord = {6'h0d, in_rs, in_rt, in_imm};
      4'd3:    encWord = {6'h23, in_rs, in_rt, in_imm};
      4'd4:    encWord = {6'h2b, in_rs, in_rt, in_imm};
      4'd5:    encWord = {6'h04, in_rs, in_rt, in_imm};
      4'd6:    encWord = {6'h0f, 5'h00, in_rt, in_imm};
      4'd7:    encWord = {6'h03, in_target};
      4'd8:    encWord = {6'h00, in_rs, 15'h0000, 6'h08};
      4'd9:    encWord = {6'h02, in_target};
      default: legal   = 1'b0;
    endcase
  end

  // A full FIFO stays closed even when a pop happens in the same cycle.
  assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign in_ready = !full && !flush;
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal;
  assign im_we    = (count != '0);
  assign pop      = im_we && im_ready;
  assign im_wdata = fifoMem[rdPtr];
  assign im_addr  = PC_BASE + (32'(offset) << 2);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr         <= '0;
      rdPtr         <= '0;
      count         <= '0;
      offset        <= '0;
      words_written <= '0;
      err_illegal   <= 1'b0;
      // NOTE: the FIFO storage is cleared on reset so im_wdata reads zero
      // afterwards; flush only rewinds the pointers and leaves stale data.
      for (int i = 0; i < FIFO_DEPTH; i++) fifoMem[i] <= '0;
    end else if (flush) begin
      wrPtr         <= '0;
      rdPtr         <= '0;
      count         <= '0;
      offset        <= '0;
      words_written <= '0;
      err_illegal   <= 1'b0;
    end else begin
      err_illegal <= accept && !legal;
      if (push) begin
        fifoMem[wrPtr] <= encWord;
        wrPtr          <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr  <= rdPtr + 1'b1;
        offset <= offset + 1'b1;
        if (words_written != '1) words_written <= words_written + 1'b1;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule
